// File: rtl/shadow_param_memory_pkg.sv
// Shared types and helpers for the shadow parameter memory.
// Holds the control FSM encoding and byte/word sizing.
package shadow_param_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL,
        COMMIT
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int bytes_per_word(input int n);
        return (n + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word assembler.
// Emits the finished word combinationally on the last byte.
module byte_word_packer
    import shadow_param_memory_pkg::*;
#(
    parameter int N = 8,
    parameter int B = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [N-1:0]      word,
    output logic              word_valid
);

    localparam int W  = B * BYTE_W;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    logic [W-1:0]  sr_q;
    logic [W-1:0]  sr_d;
    logic [CW-1:0] cnt_q;

    // New bytes enter at the top, so after B bytes the first sits in [7:0].
    assign sr_d = (sr_q >> BYTE_W) | (W'(byte_in) << (W - BYTE_W));

    assign word_valid = byte_valid && (cnt_q == CW'(B - 1));
    assign word       = sr_d[N-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (byte_valid) begin
            if (word_valid) begin
                sr_q  <= '0;
                cnt_q <= '0;
            end else begin
                sr_q  <= sr_d;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shadow_param_memory.sv
// Double-buffered parameter store: bytes load a shadow bank,
// and a commit copies it into the active bank in one edge.
module shadow_param_memory
    import shadow_param_memory_pkg::*;
#(
    parameter int M = 10,
    parameter int N = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         commit,
    input  logic [$clog2(M)-1:0]         rd_addr,
    output logic [N-1:0]                 rd_data,
    output logic [M*N-1:0]               all_data_out,
    output logic [$clog2(M+1)-1:0]       load_count,
    output logic                         load_done,
    output logic                         commit_done
);

    localparam int B  = bytes_per_word(N);
    localparam int AW = $clog2(M);
    localparam int CW = $clog2(M + 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic          clear;
    logic          accept;
    logic          do_commit;
    logic          commit_done_q;
    logic [N-1:0]  word;
    logic          word_valid;

    logic [N-1:0]  shadow_q [M];
    logic [N-1:0]  active_q [M];

    // A start request takes priority over a byte on the same cycle.
    assign accept = (state_q == LOAD) && in_valid && !start;

    byte_word_packer #(
        .N (N),
        .B (B)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .byte_valid (accept),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clear     = 1'b0;
        do_commit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (start) begin
                    ptr_d = '0;
                    clear = 1'b1;
                end else if (word_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == CW'(M - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    clear   = 1'b1;
                end else if (commit) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            commit_done_q <= do_commit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < M; j++) begin
                shadow_q[j] <= '0;
            end
        end else if (word_valid) begin
            shadow_q[ptr_q[AW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < M; j++) begin
                active_q[j] <= '0;
            end
        end else if (do_commit) begin
            for (int j = 0; j < M; j++) begin
                active_q[j] <= shadow_q[j];
            end
        end
    end

    always_comb begin
        all_data_out = '0;
        for (int j = 0; j < M; j++) begin
            all_data_out[j*N +: N] = active_q[j];
        end
    end

    assign rd_data = ({1'b0, rd_addr} < (AW + 1)'(M)) ? active_q[rd_addr] : '0;

    assign in_ready    = (state_q == LOAD);
    assign load_done   = (state_q == FULL);
    assign load_count  = ptr_q;
    assign commit_done = commit_done_q;

endmodule

// File: tb/tb_shadow_param_memory.sv
// Randomized and directed bench for shadow_param_memory
// against a behavioural model of the shadow/active banks.
module tb_shadow_param_memory;

    localparam int M = 10;
    localparam int N = 8;

    localparam int S_IDLE   = 0;
    localparam int S_LOAD   = 1;
    localparam int S_FULL   = 2;
    localparam int S_COMMIT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          commit;
    logic [3:0]    rd_addr;
    logic [7:0]    rd_data;
    logic [79:0]   all_data_out;
    logic [3:0]    load_count;
    logic          load_done;
    logic          commit_done;

    logic          start2;
    logic [7:0]    in_data2;
    logic          in_valid2;
    logic          in_ready2;
    logic          commit2;
    logic [1:0]    rd_addr2;
    logic [11:0]   rd_data2;
    logic [47:0]   all_data_out2;
    logic [2:0]    load_count2;
    logic          load_done2;
    logic          commit_done2;

    always #5 clk = ~clk;

    shadow_param_memory #(.M(M), .N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .commit       (commit),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .all_data_out (all_data_out),
        .load_count   (load_count),
        .load_done    (load_done),
        .commit_done  (commit_done)
    );

    shadow_param_memory #(.M(4), .N(12)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .start        (start2),
        .in_data      (in_data2),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .commit       (commit2),
        .rd_addr      (rd_addr2),
        .rd_data      (rd_data2),
        .all_data_out (all_data_out2),
        .load_count   (load_count2),
        .load_done    (load_done2),
        .commit_done  (commit_done2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int         mode;
    int         m_cnt;
    bit         m_cdone;
    logic [7:0] m_shadow [M];
    logic [7:0] m_active [M];

    function automatic logic [127:0] flat();
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < M; j++) r[j*8 +: 8] = m_active[j];
        return r;
    endfunction

    task automatic model_reset();
        mode    = S_IDLE;
        m_cnt   = 0;
        m_cdone = 0;
        for (int j = 0; j < M; j++) begin
            m_shadow[j] = '0;
            m_active[j] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_load_count", 128'(load_count), 128'(0));
        check("rst_load_done", 128'(load_done), 128'(0));
        check("rst_commit_done", 128'(commit_done), 128'(0));
        check("rst_all_data", 128'(all_data_out), 128'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input bit st, input bit cm, input bit vl,
                        input logic [7:0] d, input int addr);
        bit was_commit;
        logic [7:0] exp_rd;
        @(negedge clk);
        start    = st;
        commit   = cm;
        in_valid = vl;
        in_data  = d;
        rd_addr  = 4'(addr);
        was_commit = (mode == S_COMMIT);
        if (mode == S_COMMIT) begin
            for (int j = 0; j < M; j++) m_active[j] = m_shadow[j];
            mode = S_IDLE;
        end else if (st) begin
            mode  = S_LOAD;
            m_cnt = 0;
        end else if (mode == S_FULL && cm) begin
            mode = S_COMMIT;
        end else if (mode == S_LOAD && vl) begin
            m_shadow[m_cnt] = d;
            m_cnt++;
            if (m_cnt == M) mode = S_FULL;
        end
        m_cdone = was_commit;
        exp_rd = (addr < M) ? m_active[addr] : 8'h00;
        @(posedge clk);
        #1;
        check("in_ready", 128'(in_ready), 128'(mode == S_LOAD));
        check("load_done", 128'(load_done), 128'(mode == S_FULL));
        check("load_count", 128'(load_count), 128'(m_cnt));
        check("commit_done", 128'(commit_done), 128'(m_cdone));
        check("all_data_out", 128'(all_data_out), flat());
        check("rd_data", 128'(rd_data), 128'(exp_rd));
    endtask

    task automatic step2(input bit st, input bit cm, input bit vl,
                         input logic [7:0] d);
        @(negedge clk);
        start2    = st;
        commit2   = cm;
        in_valid2 = vl;
        in_data2  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  b2 [8];
        logic [11:0] w2 [4];
        logic [79:0] snap;

        reset = 1'b1;
        start = 0; commit = 0; in_valid = 0; in_data = 0; rd_addr = 0;
        start2 = 0; commit2 = 0; in_valid2 = 0; in_data2 = 0; rd_addr2 = 0;
        model_reset();
        #1;
        check("init_in_ready", 128'(in_ready), 128'(0));
        check("init_all_data", 128'(all_data_out), 128'(0));
        do_reset();

        // basic load of 0x01..0x0A then commit
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < M; i++) step(0, 0, 1, 8'(i + 1), 3);
        check("full_all_data_zero", 128'(all_data_out), 128'(0));
        check("full_count", 128'(load_count), 128'(10));
        step(0, 1, 0, 8'h00, 3);
        step(0, 0, 0, 8'h00, 3);
        check("commit_pulse", 128'(commit_done), 128'(1));
        check("rd3", 128'(rd_data), 128'(8'h04));
        check("word9", 128'(all_data_out[79:72]), 128'(8'h0A));
        step(0, 0, 0, 8'h00, 12);
        check("pulse_once", 128'(commit_done), 128'(0));

        // ignored commit / bytes in IDLE
        step(0, 1, 1, 8'h55, 1);
        step(0, 0, 1, 8'h66, 2);

        // abort and reload
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom), 0);
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < M; i++) step(0, 0, 1, 8'(8'hF0 + i), 0);
        step(0, 0, 1, 8'h77, 0);
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("abort_w0", 128'(rd_data), 128'(8'hF0));
        check("abort_w9", 128'(all_data_out[79:72]), 128'(8'hF9));

        // start wins over commit in FULL
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < M; i++) step(0, 0, 1, 8'($urandom), 0);
        snap = all_data_out;
        step(1, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("sc_no_commit", 128'(commit_done), 128'(0));
        check("sc_active_kept", 128'(all_data_out), 128'(snap));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit st;
            bit cm;
            bit vl;
            st = ($urandom_range(0, 19) == 0);
            cm = ($urandom_range(0, 3) == 0);
            vl = !st && ($urandom_range(0, 2) != 0);
            step(st, cm, vl, 8'($urandom), int'($urandom_range(0, 15)));
        end

        // reset mid-load after committed data is present
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < M; i++) step(0, 0, 1, 8'($urandom), 0);
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), 0);
        do_reset();
        step(0, 0, 0, 8'h00, 5);

        // 12-bit words on the second instance
        b2[0] = 8'h34; b2[1] = 8'h12; b2[2] = 8'hCD; b2[3] = 8'hAB;
        b2[4] = 8'h56; b2[5] = 8'hF7; b2[6] = 8'hE8; b2[7] = 8'h99;
        for (int k = 0; k < 4; k++) w2[k] = 12'({b2[2*k+1], b2[2*k]} & 16'h0FFF);
        step2(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step2(0, 0, 1, b2[i]);
        check("n12_load_done", 128'(load_done2), 128'(1));
        check("n12_pre_commit", 128'(all_data_out2), 128'(0));
        step2(0, 1, 0, 8'h00);
        step2(0, 0, 0, 8'h00);
        check("n12_commit_done", 128'(commit_done2), 128'(1));
        for (int k = 0; k < 4; k++) begin
            rd_addr2 = 2'(k);
            #1;
            check($sformatf("n12_word%0d", k), 128'(rd_data2), 128'(w2[k]));
        end
        check("n12_w0", 128'(all_data_out2[11:0]), 128'(12'h234));
        check("n12_w1", 128'(all_data_out2[23:12]), 128'(12'hBCD));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shadow_param_memory.md
SHADOW_PARAM_MEMORY -- requirements
Module: shadow_param_memory

Interface
REQ-001 SHALL have parameter M, default 10, number of parameter words.
REQ-002 SHALL have parameter N, default 8, word width in bits; derived B = ceil(N/8) bytes per word.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin or restart a load at word 0.
REQ-006 SHALL have port in_data  input  8  load byte.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a byte.
REQ-009 SHALL have port commit  input  1  copy the shadow bank to the active bank.
REQ-010 SHALL have port rd_addr  input  clog2(M)  active-bank read address.
REQ-011 SHALL have port rd_data  output  N  active[rd_addr].
REQ-012 SHALL have port all_data_out  output  M*N  active bank flattened; word j occupies bits [j*N +: N].
REQ-013 SHALL have port load_count  output  clog2(M+1)  words written to shadow in the current load.
REQ-014 SHALL have port load_done  output  1  all M shadow words loaded and awaiting commit.
REQ-015 SHALL have port commit_done  output  1  one-cycle pulse after a commit.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FULL and COMMIT.
REQ-017 IDLE: in_ready=0; start -> LOAD with word pointer=0 and byte count=0.
REQ-018 LOAD: in_ready=1; a byte is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-019 Byte order SHALL be little-endian: the first byte of each word fills bits [7:0], the next byte fills [15:8], and so on.
REQ-020 On the B-th accepted byte, the low N bits of the assembled word SHALL be written to shadow[ptr] on that same edge, and ptr SHALL increment.
REQ-021 Assembled bits at or above bit N SHALL be discarded.
REQ-022 When word M-1 is written, the FSM SHALL go to FULL; load_done=1 from the next cycle.
REQ-023 FULL: in_ready=0; load_done=1; commit -> COMMIT.
REQ-024 COMMIT: all M active words SHALL be replaced by the shadow words in a single edge.
REQ-025 After COMMIT: commit_done=1 for exactly one cycle, load_done=0, and the FSM SHALL return to IDLE.
REQ-026 Commit SHALL be ignored in IDLE and LOAD.
REQ-027 start in LOAD or FULL SHALL abort the current load: ptr and byte count to 0, load_done=0, state LOAD; shadow contents are not cleared.
REQ-028 start and commit in the same cycle in FULL: start SHALL win and commit SHALL be ignored.
REQ-029 start in COMMIT SHALL be ignored.
REQ-030 The active bank SHALL change only in COMMIT; rd_data and all_data_out SHALL be combinational from the active bank.
REQ-031 rd_addr >= M SHALL return rd_data=0.
REQ-032 load_count SHALL equal ptr, range 0..M.
REQ-033 A byte with in_valid=1 while in_ready=0 SHALL be dropped with no state change.

Reset
REQ-034 Reset SHALL set the state to IDLE; ptr, byte count and the assembly register to 0; shadow and active banks to all zeros; in_ready, load_done and commit_done to 0.
REQ-035 Reset asserted mid-LOAD or mid-COMMIT SHALL take effect immediately, and no partial commit SHALL be visible after reset.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the constant BYTE_W=8 and the function that derives B from N.
REQ-037 The byte-to-word assembler (shift register plus byte counter, N-bit output, word_valid pulse) SHALL be the sub-module byte_word_packer.
REQ-038 The shadow and active banks SHALL be separate register arrays in the top module.

Verification
REQ-039 M=10, N=8: reset, start, bytes 0x01..0x0A -> load_done=1, load_count=10, all_data_out still 0; commit -> commit_done pulse, rd_addr=3 gives 0x04, all_data_out[79:72]=0x0A.
REQ-040 M=4, N=12: start, bytes 0x34,0x12,0xCD,0xAB,... -> shadow[0]=0x234, shadow[1]=0xBCD after commit (upper nibble dropped).
REQ-041 Abort and reload: start, load 5 bytes, start, load 10 bytes 0xF0..0xF9, commit -> active[0]=0xF0 and active[9]=0xF9.
REQ-042 In FULL, drive start and commit together -> no commit_done, active unchanged, state LOAD with load_count=0.
REQ-043 Reset mid-LOAD after 6 bytes -> in_ready=0, load_count=0, and all_data_out=0 after reset.
REQ-044 commit in IDLE, and in_valid in IDLE/FULL -> ignored, with no change to the active bank or load_count.
